// File: rtl/globalconf.sv
// globalconf: shared SoC types and constants used by the bus arbiter.
package globalconf;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int ARB_DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/soc_rr_picker.sv
// soc_rr_picker: combinational round-robin select, searching upward from last+1.
module soc_rr_picker #(
  parameter int N = 3,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         valid
);
  logic [W-1:0] idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Walk from lowest to highest priority so the nearest requester overwrites.
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last) + i) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: round-robin arbiter sharing one slave port, with a hang watchdog.
module soc_bus_arbiter
  import globalconf::*;
#(
  parameter int MASTER_COUNT   = 3,
  parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT,
  localparam int GW = $clog2(MASTER_COUNT)
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [MASTER_COUNT-1:0]   m_req,
  input  logic [32*MASTER_COUNT-1:0] m_addr,
  input  logic [32*MASTER_COUNT-1:0] m_wdata,
  input  logic [4*MASTER_COUNT-1:0] m_wstrb,
  input  logic [MASTER_COUNT-1:0]   m_we,
  output logic [31:0]               m_rdata,
  output logic [MASTER_COUNT-1:0]   m_ack,
  output logic [MASTER_COUNT-1:0]   m_err,
  output logic                      s_req,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_wstrb,
  output logic                      s_we,
  input  logic [31:0]               s_rdata,
  input  logic                      s_ack,
  output logic [GW-1:0]             grant_id,
  output logic [7:0]                timeout_count
);
  arb_state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [15:0] wd_q, wd_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic pick_valid, busy, done_ack, done_to;

  soc_rr_picker #(.N(MASTER_COUNT)) u_picker (
    .req(m_req), .last(last_q), .grant(pick), .valid(pick_valid)
  );

  assign busy     = state_q == ARB_BUSY;
  assign done_ack = busy && s_ack && !res;
  // Watchdog holds the 1-based BUSY cycle number; an ack in the same cycle wins.
  assign done_to  = busy && !s_ack && !res && (TIMEOUT_CYCLES != 0) && (wd_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    s_req         = busy;
    s_addr        = busy ? m_addr[32*int'(grant_q) +: 32] : '0;
    s_wdata       = busy ? m_wdata[32*int'(grant_q) +: 32] : '0;
    s_wstrb       = busy ? m_wstrb[4*int'(grant_q) +: 4] : '0;
    s_we          = busy ? m_we[grant_q] : 1'b0;
    m_ack         = (done_ack || done_to) ? MASTER_COUNT'(1) << grant_q : '0;
    m_err         = done_to ? MASTER_COUNT'(1) << grant_q : '0;
    m_rdata       = done_ack ? s_rdata : done_to ? ARB_TIMEOUT_RDATA : '0;
    grant_id      = grant_q;
    timeout_count = tcnt_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    if (!busy && pick_valid) begin
      state_d = ARB_BUSY;
      grant_d = pick;
      wd_d    = 16'd1;
    end else if (done_ack || done_to) begin
      state_d = ARB_IDLE;
      last_d  = grant_q;
      tcnt_d  = (done_to && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
    end else if (busy) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(MASTER_COUNT - 1);
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end
endmodule
